instr_fetch_unit: RTL and testbench

- Fetch sequencer that writes the instruction register in the MIPS32 multicycle datapath.
- Owns the program counter and issues word reads to instruction memory over a req/ready handshake.
- Presents each fetched word on ir_data with a one-cycle ir_w strobe.
- Control FSM starts fetches with fetch_en; branch and jump redirects arrive on pc_load/pc_next.

---
 rtl/mips_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 12 +
 rtl/instr_fetch_unit_pc_reg.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch unit: the fetch state encoding and
// the fixed instruction constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read bus: the fetch unit is the master and the memory is the slave.
interface instr_fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter with immediate load, completion update and a pending redirect
// that is held while a fetch is in flight and applied on the return to IDLE.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_now,
    input  logic        load_pend,
    input  logic [31:0] pc_next,
    input  logic        incr,
    input  logic [31:0] incr_val,
    input  logic        enter_idle,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] plus4_q, plus4_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_v_q, pend_v_d;

    always_comb begin
        pc_d      = pc_q;
        plus4_d   = plus4_q;
        pend_pc_d = pend_pc_q;
        pend_v_d  = pend_v_q;
        if (load_pend) begin
            pend_v_d  = 1'b1;
            pend_pc_d = pc_next;
        end
        if (incr) begin
            pc_d    = incr_val;
            plus4_d = incr_val;
        end
        // A redirect seen during the fetch wins over the sequential +4 value.
        if (enter_idle && (pend_v_q || load_pend)) begin
            pc_d     = load_pend ? pc_next : pend_pc_q;
            pend_v_d = 1'b0;
        end
        if (load_now) begin
            pc_d = pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            plus4_q   <= RESET_PC + WORD_BYTES;
            pend_pc_q <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            plus4_q   <= plus4_d;
            pend_pc_q <= pend_pc_d;
            pend_v_q  <= pend_v_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_plus4 = plus4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: IDLE -> REQ -> WAIT -> DELIVER, writes the IR via ir_w.
// Define FETCH_TIMEOUT_EN to bound WAIT and complete with a NOP plus sticky fetch_err.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15,
    parameter int          TO_W     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_en,
    input  logic                pc_load,
    input  logic [31:0]         pc_next,
    instr_fetch_unit_if.master  mem,
    output logic [31:0]         ir_data,
    output logic                ir_w,
    output logic                fetch_done,
    output logic                busy,
    output logic [31:0]         pc_out,
    output logic [31:0]         pc_plus4
`ifdef FETCH_TIMEOUT_EN
    ,
    output logic                fetch_err
`endif
);

    if (TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
        $error("TIMEOUT must be representable in TO_W bits");
    end

    fetch_state_e state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_data_q, ir_data_d;
    logic        ir_w_q, ir_w_d;
    logic        busy_q, busy_d;
    logic        complete;
    logic [31:0] pc_cur;
    logic [31:0] pc_aligned;

`ifdef FETCH_TIMEOUT_EN
    logic [TO_W-1:0] to_q, to_d;
    logic            err_q, err_d;
`endif

    assign pc_aligned = {pc_next[31:2], 2'b00};

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        addr_d    = addr_q;
        ir_data_d = ir_data_q;
        ir_w_d    = 1'b0;
        complete  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        to_d      = to_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_load ? pc_aligned : pc_cur;
`ifdef FETCH_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            REQ, WAIT: begin
                if (mem.mem_ready) begin
                    state_d   = DELIVER;
                    req_d     = 1'b0;
                    ir_data_d = mem.mem_rdata;
                    ir_w_d    = 1'b1;
                    complete  = 1'b1;
                end else begin
                    state_d = WAIT;
`ifdef FETCH_TIMEOUT_EN
                    // Only WAIT cycles count; the REQ cycle is not part of the budget.
                    if (state_q == WAIT) begin
                        if (to_q == TO_W'(TIMEOUT - 1)) begin
                            state_d   = DELIVER;
                            req_d     = 1'b0;
                            ir_data_d = NOP_INSTR;
                            ir_w_d    = 1'b1;
                            complete  = 1'b1;
                            err_d     = 1'b1;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end
`endif
                end
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            addr_q    <= '0;
            ir_data_q <= '0;
            ir_w_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            ir_data_q <= ir_data_d;
            ir_w_q    <= ir_w_d;
            busy_q    <= busy_d;
`ifdef FETCH_TIMEOUT_EN
            to_q      <= to_d;
            err_q     <= err_d;
`endif
        end
    end

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_now   (pc_load && (state_q == IDLE)),
        .load_pend  (pc_load && (state_q != IDLE)),
        .pc_next    (pc_aligned),
        .incr       (complete),
        .incr_val   (addr_q + WORD_BYTES),
        .enter_idle (state_q == DELIVER),
        .pc_out     (pc_cur),
        .pc_plus4   (pc_plus4)
    );

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;
    assign ir_data      = ir_data_q;
    assign ir_w         = ir_w_q;
    assign fetch_done   = ir_w_q;
    assign busy         = busy_q;
    assign pc_out       = pc_cur;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err    = err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; timeout scenario runs when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [31:0] ir_data;
    logic        ir_w;
    logic        fetch_done;
    logic        busy;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif
    int checks = 0;
    int errors = 0;

    instr_fetch_unit_if mif ();

    instr_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_en   (fetch_en),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .mem        (mif),
        .ir_data    (ir_data),
        .ir_w       (ir_w),
        .fetch_done (fetch_done),
        .busy       (busy),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4)
`ifdef FETCH_TIMEOUT_EN
        ,
        .fetch_err  (fetch_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fetch_en = 1'b0; pc_load = 1'b0; pc_next = '0;
        mif.mem_ready = 1'b0; mif.mem_rdata = '0;
        step(); step();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_out, 32'h0); end
        checks++; if (pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_plus4: got %h exp %h", pc_plus4, 32'h4); end
        checks++; if ({mif.mem_req, ir_w, fetch_done, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {mif.mem_req, ir_w, fetch_done, busy}); end
        checks++; if (mif.mem_addr !== 32'h0 || ir_data !== 32'h0) begin errors++; $display("FAIL reset_addr_ir: addr %h ir %h exp 0", mif.mem_addr, ir_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_fetch;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL basic_req: req %b addr %h busy %b exp 1 0 1", mif.mem_req, mif.mem_addr, busy); end
        step();
        checks++; if (ir_w !== 1'b0) begin errors++; $display("FAIL basic_early_irw: got %b exp 0", ir_w); end
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h8C01_0004;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (ir_w !== 1'b1 || fetch_done !== 1'b1 || ir_data !== 32'h8C01_0004) begin errors++; $display("FAIL basic_deliver: ir_w %b done %b ir %h exp 1 1 8c010004", ir_w, fetch_done, ir_data); end
        checks++; if (pc_out !== 32'h4 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL basic_pc: pc %h req %b exp 4 0", pc_out, mif.mem_req); end
        step();
        checks++; if (ir_w !== 1'b0 || busy !== 1'b0 || ir_data !== 32'h8C01_0004) begin errors++; $display("FAIL basic_idle: ir_w %b busy %b ir %h exp 0 0 8c010004", ir_w, busy, ir_data); end
    endtask

    task automatic test_wait_states;
        int req_cycles = 0;
        int irw_hits = 0;
        pc_load = 1'b1; pc_next = 32'h100;
        step();
        pc_load = 1'b0;
        checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL ws_load: got %h exp 100", pc_out); end
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        repeat (4) begin
            if (mif.mem_req) req_cycles++;
            if (ir_w) irw_hits++;
            step();
        end
        if (mif.mem_req) req_cycles++;
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h2408_0001;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (req_cycles !== 5) begin errors++; $display("FAIL ws_req_cycles: got %0d exp 5", req_cycles); end
        checks++; if (irw_hits !== 0 || ir_w !== 1'b1) begin errors++; $display("FAIL ws_irw: early %0d now %b exp 0 1", irw_hits, ir_w); end
        checks++; if (pc_out !== 32'h104 || mif.mem_addr !== 32'h100) begin errors++; $display("FAIL ws_pc: pc %h addr %h exp 104 100", pc_out, mif.mem_addr); end
        step();
        checks++; if (ir_w !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ws_single: ir_w %b busy %b exp 0 0", ir_w, busy); end
    endtask

    task automatic test_redirect_in_wait;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        pc_load = 1'b1; pc_next = 32'h2003;
        step();
        pc_load = 1'b0;
        checks++; if (mif.mem_addr !== 32'h104 || mif.mem_req !== 1'b1) begin errors++; $display("FAIL rd_addr_held: addr %h req %b exp 104 1", mif.mem_addr, mif.mem_req); end
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h1234_5678;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (ir_w !== 1'b1 || ir_data !== 32'h1234_5678 || pc_plus4 !== 32'h108) begin errors++; $display("FAIL rd_deliver: ir_w %b ir %h plus4 %h exp 1 12345678 108", ir_w, ir_data, pc_plus4); end
        step();
        checks++; if (pc_out !== 32'h2000 || busy !== 1'b0) begin errors++; $display("FAIL rd_pc_idle: pc %h busy %b exp 2000 0", pc_out, busy); end
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        checks++; if (mif.mem_addr !== 32'h2000) begin errors++; $display("FAIL rd_next_addr: got %h exp 2000", mif.mem_addr); end
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'hAAAA_5555;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (ir_w !== 1'b1 || pc_out !== 32'h2004) begin errors++; $display("FAIL rd_min_latency: ir_w %b pc %h exp 1 2004", ir_w, pc_out); end
        step();
    endtask

    task automatic test_load_with_fetch;
        fetch_en = 1'b1; pc_load = 1'b1; pc_next = 32'h40;
        step();
        fetch_en = 1'b0; pc_load = 1'b0;
        checks++; if (mif.mem_addr !== 32'h40 || pc_out !== 32'h40) begin errors++; $display("FAIL lf_addr: addr %h pc %h exp 40 40", mif.mem_addr, pc_out); end
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h0000_0020;
        step();
        mif.mem_ready = 1'b0;
        step();
        checks++; if (pc_out !== 32'h44 || pc_plus4 !== 32'h44) begin errors++; $display("FAIL lf_pc: pc %h plus4 %h exp 44 44", pc_out, pc_plus4); end
    endtask

    task automatic test_reset_in_wait;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || mif.mem_req !== 1'b0 || pc_out !== 32'h0) begin errors++; $display("FAIL rw_reset: busy %b req %b pc %h exp 0 0 0", busy, mif.mem_req, pc_out); end
        rst_n = 1'b1;
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (ir_w !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rw_late_ready: ir_w %b busy %b exp 0 0", ir_w, busy); end
        step();
        checks++; if (ir_w !== 1'b0 || pc_out !== 32'h0 || ir_data !== 32'h0) begin errors++; $display("FAIL rw_after: ir_w %b pc %h ir %h exp 0 0 0", ir_w, pc_out, ir_data); end
    endtask

    task automatic test_wrap_and_ignore;
        pc_load = 1'b1; pc_next = 32'hFFFF_FFFC;
        step();
        pc_load = 1'b0;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (pc_out !== 32'h0 || pc_plus4 !== 32'h0 || ir_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wrap_pc: pc %h plus4 %h ir %h exp 0 0 deadbeef", pc_out, pc_plus4, ir_data); end
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        mif.mem_ready = 1'b1;
        step();
        mif.mem_ready = 1'b0;
        checks++; if (busy !== 1'b0 || ir_w !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL ignore_outside_idle: busy %b ir_w %b req %b exp 0 0 0", busy, ir_w, mif.mem_req); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        int irw_hits = 0;
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        step();
        repeat (14) begin
            if (ir_w) irw_hits++;
            step();
        end
        checks++; if (irw_hits !== 0 || ir_w !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("FAIL to_early: hits %0d ir_w %b err %b exp 0 0 0", irw_hits, ir_w, fetch_err); end
        step();
        checks++; if (ir_w !== 1'b1 || ir_data !== 32'h0 || fetch_err !== 1'b1 || pc_out !== 32'h4) begin errors++; $display("FAIL to_fire: ir_w %b ir %h err %b pc %h exp 1 0 1 4", ir_w, ir_data, fetch_err, pc_out); end
        step(); step();
        checks++; if (fetch_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky: err %b busy %b exp 1 0", fetch_err, busy); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b exp 0", fetch_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_redirect_in_wait();
        test_load_with_fetch();
        test_reset_in_wait();
        test_wrap_and_ignore();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
